// File: rtl/csr_file_if.sv
// CSR access bus between the instruction decoder (master) and the CSR file (slave).
// It carries the access strobes, the address and operand, the read result and the illegal flag.
interface csr_file_if;
    logic        CSR_read_en;
    logic        CSR_write_en;
    logic        CSR_set_en;
    logic        CSR_clear_en;
    logic [11:0] CSR_address;
    logic [31:0] CSR_write_data;
    logic [31:0] CSR_read_data;
    logic        CSR_illegal;

    modport master (
        output CSR_read_en, CSR_write_en, CSR_set_en, CSR_clear_en,
        output CSR_address, CSR_write_data,
        input  CSR_read_data, CSR_illegal
    );

    modport slave (
        input  CSR_read_en, CSR_write_en, CSR_set_en, CSR_clear_en,
        input  CSR_address, CSR_write_data,
        output CSR_read_data, CSR_illegal
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: trap/MRET state, 64-bit cycle and instret counters, read-before-write access.
// Illegal accesses leave all state untouched and raise a one-cycle CSR_illegal pulse.
module csr_file #(
    parameter int CORE            = 0,
    parameter int SCAN_CYCLES_MIN = 0,
    parameter int SCAN_CYCLES_MAX = 1000
) (
    input  logic        clock,
    input  logic        reset,
    csr_file_if.slave   bus,
    input  logic        instret_inc,
    input  logic        trap_en,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_value,
    input  logic        mret_en,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out,
    output logic        global_int_en,
    input  logic        scan
);

    logic        mstatus_mie, mstatus_mpie;
    logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [63:0] mcycle_q, minstret_q;
    logic [31:0] scan_cycles;

    logic [31:0] csr_rdata, wr_value;
    logic        implemented, read_only;
    logic        wr_any, wr_illegal, illegal, do_write;
    logic        cycle_written, instret_written;

    // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
    always_comb begin
        csr_rdata   = '0;
        implemented = 1'b1;
        read_only   = 1'b0;
        case (bus.CSR_address)
            12'h300: csr_rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
            12'h301: begin csr_rdata = 32'h4000_0100; read_only = 1'b1; end
            12'h304: csr_rdata = mie_q;
            12'h305: csr_rdata = mtvec_q;
            12'h340: csr_rdata = mscratch_q;
            12'h341: csr_rdata = mepc_q;
            12'h342: csr_rdata = mcause_q;
            12'h343: csr_rdata = mtval_q;
            12'h344: read_only = 1'b1;
            12'hB00: csr_rdata = mcycle_q[31:0];
            12'hB80: csr_rdata = mcycle_q[63:32];
            12'hB02: csr_rdata = minstret_q[31:0];
            12'hB82: csr_rdata = minstret_q[63:32];
            12'hC00: begin csr_rdata = mcycle_q[31:0];    read_only = 1'b1; end
            12'hC80: begin csr_rdata = mcycle_q[63:32];   read_only = 1'b1; end
            12'hC02: begin csr_rdata = minstret_q[31:0];  read_only = 1'b1; end
            12'hC82: begin csr_rdata = minstret_q[63:32]; read_only = 1'b1; end
            12'hF14: begin csr_rdata = 32'(CORE);         read_only = 1'b1; end
            default: implemented = 1'b0;
        endcase
    end

    // A trap swallows any same-cycle modifying access, including its illegal flag.
    assign wr_any     = bus.CSR_write_en | bus.CSR_set_en | bus.CSR_clear_en;
    assign wr_illegal = wr_any & ((bus.CSR_address[11:10] == 2'b11) | read_only | ~implemented);
    assign illegal    = (wr_illegal & ~trap_en) | (bus.CSR_read_en & ~implemented);
    assign do_write   = wr_any & ~wr_illegal & ~trap_en;

    assign wr_value = bus.CSR_write_en ? bus.CSR_write_data :
                      bus.CSR_set_en   ? (csr_rdata |  bus.CSR_write_data) :
                                         (csr_rdata & ~bus.CSR_write_data);

    assign cycle_written   = do_write & ((bus.CSR_address == 12'hB00) | (bus.CSR_address == 12'hB80));
    assign instret_written = do_write & ((bus.CSR_address == 12'hB02) | (bus.CSR_address == 12'hB82));

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            mstatus_mie       <= 1'b0;
            mstatus_mpie      <= 1'b0;
            mie_q             <= '0;
            mtvec_q           <= '0;
            mscratch_q        <= '0;
            mepc_q            <= '0;
            mcause_q          <= '0;
            mtval_q           <= '0;
            mcycle_q          <= '0;
            minstret_q        <= '0;
            scan_cycles       <= '0;
            bus.CSR_read_data <= '0;
            bus.CSR_illegal   <= 1'b0;
        end else begin
            scan_cycles     <= scan_cycles + 32'd1;
            bus.CSR_illegal <= illegal;
            if (bus.CSR_read_en)
                bus.CSR_read_data <= csr_rdata;
            if (!cycle_written)
                mcycle_q <= mcycle_q + 64'd1;
            if (instret_inc && !instret_written)
                minstret_q <= minstret_q + 64'd1;

            if (trap_en) begin
                mepc_q       <= trap_pc & ~32'd3;
                mcause_q     <= trap_cause;
                mtval_q      <= trap_value;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (mret_en) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end

            // Software access lands last, so it wins over MRET on mstatus in the same cycle.
            if (do_write) begin
                case (bus.CSR_address)
                    12'h300: begin
                        mstatus_mie  <= wr_value[3];
                        mstatus_mpie <= wr_value[7];
                    end
                    12'h304: mie_q      <= wr_value;
                    12'h305: mtvec_q    <= {wr_value[31:2], 2'b00};
                    12'h340: mscratch_q <= wr_value;
                    12'h341: mepc_q     <= {wr_value[31:2], 2'b00};
                    12'h342: mcause_q   <= wr_value;
                    12'h343: mtval_q    <= wr_value;
                    12'hB00: mcycle_q   <= {mcycle_q[63:32], wr_value};
                    12'hB80: mcycle_q   <= {wr_value, mcycle_q[31:0]};
                    12'hB02: minstret_q <= {minstret_q[63:32], wr_value};
                    12'hB82: minstret_q <= {wr_value, minstret_q[31:0]};
                    default: ;
                endcase
            end
        end
    end

    assign mtvec_out     = mtvec_q;
    assign mepc_out      = mepc_q;
    assign global_int_en = mstatus_mie;

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset && scan && int'(scan_cycles) >= SCAN_CYCLES_MIN
                && int'(scan_cycles) <= SCAN_CYCLES_MAX)
            $display("[csr %0d] cyc=%0d addr=%03h r=%b w=%b s=%b c=%b rdata=%08h mstatus=%b/%b mcycle=%0d",
                     CORE, scan_cycles, bus.CSR_address, bus.CSR_read_en, bus.CSR_write_en,
                     bus.CSR_set_en, bus.CSR_clear_en, bus.CSR_read_data,
                     mstatus_mpie, mstatus_mie, mcycle_q);
    end
`endif

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file; expected values are worked out by hand from the CSR behaviour.
// Inputs change 1 ns after the rising edge and outputs are sampled at that same point.
module tb_csr_file;
    logic        clock = 1'b0;
    logic        reset;
    logic        instret_inc, trap_en, mret_en, scan;
    logic [31:0] trap_pc, trap_cause, trap_value;
    logic [31:0] mtvec_out, mepc_out;
    logic        global_int_en;
    logic [31:0] rd;
    int          n_checks = 0;
    int          n_errors = 0;

    csr_file_if bus();

    csr_file #(.CORE(0), .SCAN_CYCLES_MIN(0), .SCAN_CYCLES_MAX(1000)) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus.slave),
        .instret_inc   (instret_inc),
        .trap_en       (trap_en),
        .trap_pc       (trap_pc),
        .trap_cause    (trap_cause),
        .trap_value    (trap_value),
        .mret_en       (mret_en),
        .mtvec_out     (mtvec_out),
        .mepc_out      (mepc_out),
        .global_int_en (global_int_en),
        .scan          (scan)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic csr_op(input logic r, input logic w, input logic s, input logic c,
                          input logic [11:0] addr, input logic [31:0] data);
        bus.CSR_read_en    = r;
        bus.CSR_write_en   = w;
        bus.CSR_set_en     = s;
        bus.CSR_clear_en   = c;
        bus.CSR_address    = addr;
        bus.CSR_write_data = data;
        tick();
        bus.CSR_read_en  = 1'b0;
        bus.CSR_write_en = 1'b0;
        bus.CSR_set_en   = 1'b0;
        bus.CSR_clear_en = 1'b0;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        csr_op(1'b0, 1'b1, 1'b0, 1'b0, addr, data);
    endtask

    task automatic csr_read(input logic [11:0] addr, output logic [31:0] value);
        csr_op(1'b1, 1'b0, 1'b0, 1'b0, addr, 32'h0);
        value = bus.CSR_read_data;
    endtask

    initial begin
        reset = 1'b1;
        instret_inc = 1'b0; trap_en = 1'b0; mret_en = 1'b0; scan = 1'b0;
        trap_pc = '0; trap_cause = '0; trap_value = '0;
        bus.CSR_read_en = 1'b0; bus.CSR_write_en = 1'b0; bus.CSR_set_en = 1'b0;
        bus.CSR_clear_en = 1'b0; bus.CSR_address = '0; bus.CSR_write_data = '0;

        // Reset state
        tick(); tick();
        check("rst_rdata",   bus.CSR_read_data, 0);
        check("rst_illegal", bus.CSR_illegal,   0);
        check("rst_mtvec",   mtvec_out,         0);
        check("rst_mepc",    mepc_out,          0);
        check("rst_gie",     global_int_en,     0);
        reset = 1'b0;
        tick();
        csr_read(12'hB00, rd);
        check("mcycle_after_reset", rd, 1);

        // Plain write then read back
        csr_write(12'h340, 32'hDEADBEEF);
        csr_read(12'h340, rd);
        check("mscratch_rw", rd, 32'hDEADBEEF);

        // Read-before-write with set; then write > set > clear priority
        csr_write(12'h340, 32'hF0);
        csr_op(1'b1, 1'b0, 1'b1, 1'b0, 12'h340, 32'h0F);
        check("set_old_value", bus.CSR_read_data, 32'hF0);
        csr_read(12'h340, rd);
        check("set_new_value", rd, 32'hFF);
        csr_op(1'b0, 1'b0, 1'b0, 1'b1, 12'h340, 32'h0F);
        csr_read(12'h340, rd);
        check("clear_value", rd, 32'hF0);
        csr_op(1'b0, 1'b1, 1'b1, 1'b1, 12'h340, 32'h3);
        csr_read(12'h340, rd);
        check("wsc_priority", rd, 32'h3);

        // mcycle low-to-high carry
        csr_write(12'hB00, 32'hFFFFFFFF);
        csr_write(12'hB80, 32'h0);
        tick();
        csr_read(12'hB00, rd);
        check("mcycle_carry_lo", rd, 0);
        csr_read(12'hB80, rd);
        check("mcycle_carry_hi", rd, 1);

        // mcycle 64-bit wrap
        csr_write(12'hB00, 32'hFFFFFFFF);
        csr_write(12'hB80, 32'hFFFFFFFF);
        tick();
        csr_read(12'hB80, rd);
        check("mcycle_wrap_hi", rd, 0);
        csr_read(12'hC00, rd);
        check("mcycle_wrap_lo", rd, 1);

        // minstret: writes suppress the same-cycle increment
        instret_inc = 1'b1;
        csr_write(12'hB02, 32'd10);
        csr_write(12'hB82, 32'd0);
        tick(); tick();
        instret_inc = 1'b0;
        csr_read(12'hC02, rd);
        check("minstret_count", rd, 12);
        csr_read(12'hC82, rd);
        check("minstret_hi", rd, 0);

        // mtvec low bits, read-only CSRs
        csr_write(12'h305, 32'h123);
        check("mtvec_out_align", mtvec_out, 32'h120);
        csr_read(12'hF14, rd);
        check("mhartid", rd, 0);
        csr_write(12'h301, 32'h0);
        check("misa_write_illegal", bus.CSR_illegal, 1);
        csr_read(12'h301, rd);
        check("misa_value", rd, 32'h40000100);
        check("misa_read_legal", bus.CSR_illegal, 0);

        // Trap entry with a same-cycle write that must be dropped
        csr_write(12'h300, 32'h8);
        check("gie_set", global_int_en, 1);
        csr_read(12'h300, rd);
        check("mstatus_mie", rd, 32'h1808);
        csr_write(12'h340, 32'h55);
        trap_en = 1'b1; trap_pc = 32'h1003; trap_cause = 32'hB; trap_value = 32'h77;
        csr_write(12'h340, 32'hAA);
        trap_en = 1'b0;
        check("trap_no_illegal", bus.CSR_illegal, 0);
        check("trap_mepc", mepc_out, 32'h1000);
        check("trap_gie", global_int_en, 0);
        csr_read(12'h342, rd);
        check("trap_mcause", rd, 32'hB);
        csr_read(12'h343, rd);
        check("trap_mtval", rd, 32'h77);
        csr_read(12'h300, rd);
        check("trap_mstatus", rd, 32'h1880);
        csr_read(12'h340, rd);
        check("trap_mscratch_kept", rd, 32'h55);
        mret_en = 1'b1;
        tick();
        mret_en = 1'b0;
        check("mret_gie", global_int_en, 1);
        csr_read(12'h300, rd);
        check("mret_mstatus", rd, 32'h1888);

        // Illegal write to a shadow: one-cycle pulse, mcycle only free-runs
        csr_read(12'hB00, rd);
        begin
            logic [31:0] base;
            base = rd;
            csr_write(12'hC00, 32'd5);
            check("shadow_write_illegal", bus.CSR_illegal, 1);
            tick();
            check("illegal_one_cycle", bus.CSR_illegal, 0);
            csr_read(12'hB00, rd);
            check("mcycle_after_illegal", rd, base + 32'd3);
        end
        csr_read(12'h7C0, rd);
        check("unimpl_read_zero", rd, 0);
        check("unimpl_read_illegal", bus.CSR_illegal, 1);

        // Reset with a trap, an illegal write and a read all in flight
        csr_read(12'h305, rd);
        check("mtvec_before_reset", rd, 32'h120);
        reset = 1'b1;
        trap_en = 1'b1; trap_pc = 32'h2000;
        csr_op(1'b1, 1'b1, 1'b0, 1'b0, 12'hC00, 32'h1);
        trap_en = 1'b0;
        reset = 1'b0;
        check("rst_trap_rdata",   bus.CSR_read_data, 0);
        check("rst_trap_illegal", bus.CSR_illegal,   0);
        check("rst_trap_mtvec",   mtvec_out,         0);
        check("rst_trap_mepc",    mepc_out,          0);
        check("rst_trap_gie",     global_int_en,     0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
